// File: rtl/batch_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// batch_dispatch_ctrl
//
// Sequences the batch pool between the conflict checker and the batch array.
// Each compatible tx is appended to the open batch. The open batch is closed
// when it becomes full, when a conflicting tx arrives, on flush and, optionally,
// after an idle timeout. Closed batches go to the executor in order over a
// valid/ready handshake. They are retired on in-order exec_done, and their IDs
// are recycled as a ring.
//
// Optional feature macro: BATCH_TIMEOUT_EN
//   defined   : an idle timer closes a non-empty open batch after TIMEOUT_CYCLES
//   undefined : no timer logic; batches close on full / conflict / flush only
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   chk_valid        conflict-check result valid
//   chk_no_conflict  1: tx fits the open batch, 0: conflicts with it
//   chk_ready        controller accepts the result this cycle
//   flush            close the open batch if it is non-empty
//   tx_append        1-cycle pulse: write tx into batch open_batch_id
//   open_batch_id    ID of the open batch
//   open_tx_count    number of tx already in the open batch
//   disp_valid       a closed batch is waiting for the executor
//   disp_batch_id    oldest undispatched closed batch
//   disp_tx_count    its tx count
//   disp_ready       executor takes the batch
//   exec_done        executor finished a batch
//   exec_done_id     ID of the finished batch
//   err_done         sticky: spurious or out-of-order exec_done seen
// -----------------------------------------------------------------------------
module batch_dispatch_ctrl #(
    parameter int  TX_PER_BATCH   = 48,
    parameter int  BATCH_ID_W     = 8,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int CNT_W          = $clog2(TX_PER_BATCH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_valid,
    input  logic                  chk_no_conflict,
    output logic                  chk_ready,
    input  logic                  flush,
    output logic                  tx_append,
    output logic [BATCH_ID_W-1:0] open_batch_id,
    output logic [CNT_W-1:0]      open_tx_count,
    output logic                  disp_valid,
    output logic [BATCH_ID_W-1:0] disp_batch_id,
    output logic [CNT_W-1:0]      disp_tx_count,
    input  logic                  disp_ready,
    input  logic                  exec_done,
    input  logic [BATCH_ID_W-1:0] exec_done_id,
    output logic                  err_done
);

    localparam int NUM_BATCHES = 2 ** BATCH_ID_W;

    typedef enum logic {
        S_OPEN  = 1'b0,
        S_STALL = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [BATCH_ID_W-1:0] alloc_q, alloc_d;
    logic [BATCH_ID_W-1:0] disp_q, disp_d;
    logic [BATCH_ID_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;

    // NOTE: the count array holds no reset; an entry is only read after the
    // close that wrote it, so reset would cost flops and buy nothing.
    logic [CNT_W-1:0]      count_mem [NUM_BATCHES];

    logic                  ready_int, accept, close;
    logic                  conflict_close, full_close, flush_close, timeout_close;
    logic [CNT_W-1:0]      fill_cnt;
    logic                  disp_pend, disp_fire, retire_fire;
    logic [BATCH_ID_W-1:0] alloc_inc, alloc_inc2;

`ifdef BATCH_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    assign alloc_inc  = alloc_q + 1'b1;
    assign alloc_inc2 = alloc_q + BATCH_ID_W'(2);
    assign disp_pend  = (disp_q != alloc_q);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        alloc_d        = alloc_q;
        disp_d         = disp_q;
        retire_d       = retire_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        ready_int      = 1'b0;
        accept         = 1'b0;
        close          = 1'b0;
        conflict_close = 1'b0;
        full_close     = 1'b0;
        flush_close    = 1'b0;
        timeout_close  = 1'b0;
        fill_cnt       = cnt_q;
`ifdef BATCH_TIMEOUT_EN
        timer_d        = '0;
`endif

        disp_fire = disp_pend && disp_ready;
        if (disp_fire) disp_d = disp_q + 1'b1;

        // Only the oldest dispatched batch may retire; anything else is an error.
        retire_fire = exec_done && (exec_done_id == retire_q) && (retire_q != disp_q);
        if (retire_fire)    retire_d = retire_q + 1'b1;
        else if (exec_done) err_d    = 1'b1;

        case (state_q)
            S_OPEN: begin
                // A conflict against a non-empty batch is held off for one
                // cycle while that batch closes; against an empty batch it
                // simply starts the batch.
                conflict_close = chk_valid && !chk_no_conflict && (cnt_q != '0);
                ready_int      = !conflict_close;
                accept         = chk_valid && ready_int;
                fill_cnt       = cnt_q + CNT_W'(accept);
                full_close     = accept && (fill_cnt == CNT_W'(TX_PER_BATCH));
                flush_close    = flush && (fill_cnt != '0);
`ifdef BATCH_TIMEOUT_EN
                timeout_close  = (cnt_q != '0) && !accept &&
                                 (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`endif
                // Every trigger closes the same batch with the same count
                // (a tx accepted this cycle belongs to it), so trigger
                // priority does not change the recorded count.
                close = full_close || conflict_close || flush_close || timeout_close;
                cnt_d = fill_cnt;
`ifdef BATCH_TIMEOUT_EN
                if ((cnt_q != '0) && !accept && !close) timer_d = timer_q + 1'b1;
`endif
                if (close) begin
                    cnt_d   = '0;
                    alloc_d = alloc_inc;
                    // The new open batch would be the last free ID: stall
                    // unless a retire frees a slot in this same cycle.
                    if (alloc_inc2 == retire_d) state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (alloc_inc != retire_q) state_d = S_OPEN;
            end
            default: state_d = S_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OPEN;
            alloc_q  <= '0;
            disp_q   <= '0;
            retire_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
`ifdef BATCH_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            alloc_q  <= alloc_d;
            disp_q   <= disp_d;
            retire_q <= retire_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`ifdef BATCH_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (close) count_mem[alloc_q] <= fill_cnt;
    end

    // Reset is synchronous, so state is stale during the reset cycle; the
    // outputs are forced low to keep that cycle free of pulses.
    assign chk_ready     = !rst && ready_int;
    assign tx_append     = !rst && accept;
    assign open_batch_id = rst ? '0 : alloc_q;
    assign open_tx_count = rst ? '0 : cnt_q;
    assign disp_valid    = !rst && disp_pend;
    assign disp_batch_id = rst ? '0 : disp_q;
    assign disp_tx_count = (!rst && disp_pend) ? count_mem[disp_q] : '0;
    assign err_done      = !rst && err_q;

endmodule
